uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmit path among NREQ independent byte-stream requesters. It sits between the client logic and the UART core's Tx FIFO write port (write_uart / write_data), holding a grant for a whole packet so bytes from different clients never interleave on the serial line. It back-pressures clients on Tx FIFO full and caps packet length.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- DBITS, 8: data word width; must equal the UART core's DBITS.
- MAX_LEN, 16: maximum beats per packet before forced termination, ≥2.

Ports:
- clk_100MHz  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  NREQ*DBITS  per-requester byte; requester i uses bits [i*DBITS +: DBITS].
- req_last  input  NREQ  marks the final byte of the packet.
- req_ready  output  NREQ  per-requester accept; a byte transfers when valid & ready.
- tx_full  input  1  Tx FIFO full flag from the UART core.
- write_uart  output  1  Tx FIFO write strobe, one cycle per byte.
- write_data  output  DBITS  byte written to the Tx FIFO.
- grant_id  output  $clog2(NREQ)  index of the current or last granted requester.
- busy  output  1  high while a packet is granted.
- pkt_trunc  output  1  one-cycle pulse when a packet is cut at MAX_LEN.

## Operation
- FSM states: IDLE, HDR (only with the macro), STREAM.
- IDLE
  - If any req_valid is high, select the first valid requester starting at rr_ptr and wrapping modulo NREQ.
  - Register the selection into grant_id and move to HDR or STREAM.
  - If no requester is valid, stay in IDLE.
- STREAM
  - req_ready[grant_id] = ~tx_full. All other req_ready bits are 0.
  - write_uart = req_valid[grant_id] & ~tx_full.
  - write_data = req_data of the granted requester.
- Beat counter: width $clog2(MAX_LEN+1), cleared on entry to STREAM, incremented per accepted byte.
- Packet end, on an accepted byte, whichever comes first:
  - req_last = 1: return to IDLE.
  - Counter reaches MAX_LEN with req_last = 0: return to IDLE and pulse pkt_trunc in the same cycle.
- On packet end, rr_ptr ← (grant_id+1) mod NREQ.
- If the granted requester drops valid mid-packet, the grant is held indefinitely. There is no timeout.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0, counter 0.
  - req_ready 0, write_uart 0, write_data 0, busy 0, pkt_trunc 0.
- req_ready, write_uart and write_data are combinational from the registered state, grant_id and the inputs. There are no registered data outputs.
- Latency without the macro:
  - Valid seen in IDLE at cycle T → grant registered at T+1 → first byte can transfer at T+1.
  - Back-to-back bytes at one per cycle while tx_full = 0.
- After packet end, one idle arbitration cycle occurs before the next grant. A requester valid during the final beat is considered in that next IDLE cycle.
- tx_full high: no transfer. Counter and state hold. Data must be held by the requester (standard valid/ready).
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned.

## Configuration
- UART_ARB_HEADER_EN defined:
  - After arbitration, the FSM enters HDR for one transfer.
  - It writes header byte {4'hA, grant_id zero-extended to 4 bits} (DBITS = 8 required) with write_uart = ~tx_full and all req_ready = 0.
  - It leaves HDR for STREAM when the header is accepted (tx_full = 0).
  - The header is not counted against MAX_LEN.
- Undefined: the HDR state and header logic are absent, and IDLE goes directly to STREAM.

## Structure
- Shared package uart_pkg:
  - FSM state enum (IDLE, HDR, STREAM).
  - Header nibble constant 4'hA.
  - Default DBITS.
- Sub-module rr_select: combinational round-robin priority picker (inputs: request vector, rr_ptr; outputs: found, index). Reusable by future Rx-side dispatch logic.

## Test plan
- Single requester 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), tx_full = 0:
  - write_uart is high for 3 consecutive cycles.
  - write_data is 0x11, 0x22, 0x33.
  - busy falls the cycle after 0x33.
- Requesters 0 and 2 both valid from reset, 2-byte packets each:
  - Order is req0 packet, one idle cycle, then req2 packet.
  - rr_ptr ends at 3.
  - No interleaving.
- tx_full held high for 5 cycles mid-packet:
  - write_uart and req_ready are 0 for those cycles.
  - The held byte is written on the first cycle tx_full = 0.
  - The count is unchanged.
- MAX_LEN = 16, requester streams 20 bytes with last on byte 20:
  - pkt_trunc pulses on byte 16 and the grant is released.
  - Bytes 17–20 go out as a separate packet after re-arbitration.
- reset low during the 2nd byte of a packet:
  - All outputs are 0 while reset is low.
  - After release, arbitration restarts from requester 0.
- With UART_ARB_HEADER_EN, requester 3 sends 0x5C (last):
  - write_data sequence is 0xA3, then 0x5C.
  - req_ready[3] = 0 during the header cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side arbitration logic.
//   - arb_state_t : arbiter FSM states (IDLE, HDR, STREAM)
//   - HDR_NIBBLE  : upper nibble of the optional per-packet header byte
//   - DBITS_DEFAULT : default UART data width
//   - hdr_byte()  : builds the header byte from a 4-bit requester id
package uart_pkg;

  localparam int         DBITS_DEFAULT = 8;
  localparam logic [3:0] HDR_NIBBLE    = 4'hA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2
  } arb_state_t;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_NIBBLE, id};
  endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin priority picker.
// Returns the first set bit of i_req found when scanning upward from i_ptr,
// wrapping modulo N.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [W-1:0]  highest-priority index for this pick (must be < N)
//   o_found          at least one request is set
//   o_idx   [W-1:0]  selected index (0 when nothing is found)
module rr_select #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Scan from lowest priority to highest; the last hit written wins, so
  // the requester closest to i_ptr is the one that sticks.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(i_ptr) + i;
      if (j >= N) j = j - N;
      if (i_req[W'(j)]) begin
        o_found = 1'b1;
        o_idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of the UART
// Tx FIFO write port. A grant is held for a whole packet so bytes from
// different clients never interleave; packets are cut at MAX_LEN beats.
//
// Optional feature: define UART_ARB_HEADER_EN to emit a header byte
// {4'hA, grant_id} before each packet (requires DBITS = 8).
//
// Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
// in the same cycle; the requester holds data/last stable until then.
// The FIFO side is write_uart, asserted only when tx_full is low.
//
// Ports:
//   clk_100MHz, reset (async, active low)
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_full, write_uart, write_data       : Tx FIFO write port
//   grant_id  : current or last granted requester
//   busy      : packet in progress
//   pkt_trunc : pulse on the beat that hits MAX_LEN without req_last
//   o_dbg_state, o_dbg_rr_ptr : FSM state and round-robin pointer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBITS   = DBITS_DEFAULT,
  parameter int MAX_LEN = 16,
  parameter int GW      = $clog2(NREQ)
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DBITS-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  tx_full,
  output logic                  write_uart,
  output logic [DBITS-1:0]      write_data,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  pkt_trunc,
  output logic [1:0]            o_dbg_state,
  output logic [GW-1:0]         o_dbg_rr_ptr
);

  localparam int CW = $clog2(MAX_LEN + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [GW-1:0]    r_rr_ptr;
  logic [GW-1:0]    r_grant_id;
  logic [CW-1:0]    r_cnt;

  logic             w_sel_found;
  logic [GW-1:0]    w_sel_idx;
  logic             w_g_valid;
  logic             w_g_last;
  logic [DBITS-1:0] w_g_data;
  logic             w_accept;
  logic             w_at_max;
  logic             w_end;
  logic [GW-1:0]    w_next_ptr;

  rr_select #(.N(NREQ), .W(GW)) u_rr_select (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  // Granted requester's signals.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == r_grant_id) begin
        w_g_valid = req_valid[i];
        w_g_last  = req_last[i];
        w_g_data  = req_data[i*DBITS +: DBITS];
      end
    end
  end

  assign w_accept   = (r_state == STREAM) & w_g_valid & ~tx_full;
  // Counter holds beats already accepted, so this beat is number r_cnt+1.
  assign w_at_max   = (r_cnt == CW'(MAX_LEN - 1));
  assign w_end      = w_accept & (w_g_last | w_at_max);
  assign w_next_ptr = (r_grant_id == GW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef UART_ARB_HEADER_EN
  logic [3:0] w_gid4;
  always_comb begin
    w_gid4           = '0;
    w_gid4[GW-1:0]   = r_grant_id;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    write_uart  = 1'b0;
    write_data  = '0;
    pkt_trunc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
`ifdef UART_ARB_HEADER_EN
          w_state_nxt = HDR;
`else
          w_state_nxt = STREAM;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      HDR: begin
        write_uart = ~tx_full;
        write_data = DBITS'(hdr_byte(w_gid4));
        if (!tx_full) w_state_nxt = STREAM;
      end
`endif
      STREAM: begin
        for (int i = 0; i < NREQ; i++) begin
          if (GW'(i) == r_grant_id) req_ready[i] = ~tx_full;
        end
        write_uart = w_accept;
        write_data = w_g_data;
        pkt_trunc  = w_accept & ~w_g_last & w_at_max;
        if (w_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_sel_found) begin
        r_grant_id <= w_sel_idx;
        r_cnt      <= '0;
      end
      if (w_accept) begin
        if (w_end) begin
          r_cnt    <= '0;
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign grant_id     = r_grant_id;
  assign busy         = (r_state != IDLE);
  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4, DBITS=8, MAX_LEN=16).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Written bytes are checked against an expected queue.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_full;
  logic        write_uart;
  logic [7:0]  write_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        pkt_trunc;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_rr_ptr;

  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_arbiter #(.NREQ(4), .DBITS(8), .MAX_LEN(16)) dut (
    .clk_100MHz   (clk_100MHz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_full      (tx_full),
    .write_uart   (write_uart),
    .write_data   (write_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .pkt_trunc    (pkt_trunc),
    .o_dbg_state  (dbg_state),
    .o_dbg_rr_ptr (dbg_rr_ptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  logic [7:0] src_data [4][32];
  logic       src_last [4][32];
  int         src_len  [4];
  int         src_pos  [4];

  logic [31:0] wr_tr, busy_tr, trunc_tr, rdy_tr;
  logic [1:0]  gid_tr [32];
  int          tr_idx;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_src();
    for (int r = 0; r < NREQ; r++) begin
      src_len[r] = 0;
      src_pos[r] = 0;
    end
  endtask

  task automatic load(input int r, input logic [7:0] d, input logic l);
    src_data[r][src_len[r]] = d;
    src_last[r][src_len[r]] = l;
    src_len[r]++;
  endtask

  task automatic trace_clear();
    wr_tr = '0; busy_tr = '0; trunc_tr = '0; rdy_tr = '0;
    for (int k = 0; k < 32; k++) gid_tr[k] = '0;
    tr_idx = 0;
  endtask

  task automatic present();
    for (int r = 0; r < NREQ; r++) begin
      if (src_pos[r] < src_len[r]) begin
        req_valid[r]       = 1'b1;
        req_data[r*8 +: 8] = src_data[r][src_pos[r]];
        req_last[r]        = src_last[r][src_pos[r]];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[r*8 +: 8] = 8'h00;
        req_last[r]        = 1'b0;
      end
    end
  endtask

  // Driver + monitor: one cycle per iteration, always bounded by n.
  task automatic run_cycles(input int n);
    logic [3:0] acc;
    repeat (n) begin
      present();
      @(negedge clk_100MHz);
      acc = req_valid & req_ready;
      if (tr_idx < 32) begin
        wr_tr[tr_idx]    = write_uart;
        busy_tr[tr_idx]  = busy;
        trunc_tr[tr_idx] = pkt_trunc;
        rdy_tr[tr_idx]   = |req_ready;
        gid_tr[tr_idx]   = grant_id;
      end
      tr_idx++;
      if (write_uart) begin
        if (exp_q.size() == 0) check_eq("unexpected_write", {24'h0, write_data}, 32'hFFFF_FFFF);
        else                   check_eq("write_data", {24'h0, write_data}, {24'h0, exp_q.pop_front()});
      end
      @(posedge clk_100MHz);
      #1;
      for (int r = 0; r < NREQ; r++) if (acc[r]) src_pos[r]++;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    tx_full = 1'b0;
    clear_src();
    present();
    exp_q.delete();
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    tx_full   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_src();
    trace_clear();

    // Reset state
    repeat (2) @(negedge clk_100MHz);
    check_eq("rst_write_uart", write_uart, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_pkt_trunc", pkt_trunc, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_rr_ptr", dbg_rr_ptr, 0);
    @(posedge clk_100MHz);
    #1;
    reset = 1'b1;

    // Single requester, 3 bytes
    trace_clear();
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    run_cycles(5);
    check_eq("t1_write_uart_trace", wr_tr[4:0], 5'b01110);
    check_eq("t1_busy_trace", busy_tr[4:0], 5'b01110);
    check_eq("t1_ready_trace", rdy_tr[4:0], 5'b01110);
    check_eq("t1_rr_ptr", dbg_rr_ptr, 1);
    check_eq("t1_exp_left", exp_q.size(), 0);

    // Requesters 0 and 2 valid from reset
    do_reset();
    trace_clear();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    run_cycles(7);
    check_eq("t2_write_uart_trace", wr_tr[6:0], 7'b0110110);
    check_eq("t2_busy_trace", busy_tr[6:0], 7'b0110110);
    check_eq("t2_grant_first", gid_tr[1], 0);
    check_eq("t2_grant_second", gid_tr[4], 2);
    check_eq("t2_rr_ptr", dbg_rr_ptr, 3);
    check_eq("t2_exp_left", exp_q.size(), 0);

    // tx_full held 5 cycles mid-packet (rr_ptr = 3, only req1 valid)
    trace_clear();
    load(1, 8'hB1, 1'b0); load(1, 8'hB2, 1'b0); load(1, 8'hB3, 1'b1);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    run_cycles(2);
    tx_full = 1'b1;
    run_cycles(5);
    tx_full = 1'b0;
    run_cycles(3);
    check_eq("t3_write_uart_trace", wr_tr[9:0], 10'b0110000010);
    check_eq("t3_ready_trace", rdy_tr[9:0], 10'b0110000010);
    check_eq("t3_busy_trace", busy_tr[9:0], 10'b0111111110);
    check_eq("t3_grant_held", gid_tr[4], 1);
    check_eq("t3_exp_left", exp_q.size(), 0);

    // 20-byte stream truncated at 16 (rr_ptr = 2)
    trace_clear();
    for (int k = 0; k < 20; k++) begin
      load(0, 8'(8'h40 + k), (k == 19));
      exp_q.push_back(8'(8'h40 + k));
    end
    run_cycles(23);
    check_eq("t4_write_uart_trace", wr_tr & 32'h007F_FFFF, 32'h003D_FFFE);
    check_eq("t4_trunc_trace", trunc_tr & 32'h007F_FFFF, 32'h0001_0000);
    check_eq("t4_busy_trace", busy_tr & 32'h007F_FFFF, 32'h003D_FFFE);
    check_eq("t4_regrant", gid_tr[18], 0);
    check_eq("t4_rr_ptr", dbg_rr_ptr, 1);
    check_eq("t4_exp_left", exp_q.size(), 0);

    // Reset during the 2nd byte (rr_ptr = 1)
    trace_clear();
    load(1, 8'hD1, 1'b0); load(1, 8'hD2, 1'b0); load(1, 8'hD3, 1'b1);
    exp_q.push_back(8'hD1);
    run_cycles(2);
    present();
    reset = 1'b0;
    #1;
    check_eq("t5_rst_write_uart", write_uart, 0);
    check_eq("t5_rst_req_ready", req_ready, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_write_data", write_data, 0);
    check_eq("t5_rst_pkt_trunc", pkt_trunc, 0);
    check_eq("t5_rst_grant_id", grant_id, 0);
    check_eq("t5_rst_rr_ptr", dbg_rr_ptr, 0);
    check_eq("t5_exp_left", exp_q.size(), 0);
    clear_src();
    present();
    @(posedge clk_100MHz);
    #1;
    reset = 1'b1;
    trace_clear();
    load(3, 8'hE3, 1'b1);
    load(0, 8'hE0, 1'b1);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE3);
    run_cycles(5);
    check_eq("t5_write_uart_trace", wr_tr[4:0], 5'b01010);
    check_eq("t5_first_grant", gid_tr[1], 0);
    check_eq("t5_second_grant", gid_tr[3], 3);
    check_eq("t5_exp_left2", exp_q.size(), 0);

`ifdef UART_ARB_HEADER_EN
    // Header byte before requester 3's packet
    do_reset();
    trace_clear();
    load(3, 8'h5C, 1'b1);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h5C);
    run_cycles(4);
    check_eq("t6_write_uart_trace", wr_tr[3:0], 4'b0110);
    check_eq("t6_ready_trace", rdy_tr[3:0], 4'b0100);
    check_eq("t6_exp_left", exp_q.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
